// File: rtl/rv_pkg.sv
// Shared ISA constants and enums for the multi-cycle reduced RISC-V core.
// Decoding is kept here so that the core and any future stage share one classification.
package rv_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'd0;
    localparam logic [2:0] F3_BEQ = 3'd0;
    localparam logic [2:0] F3_BNE = 3'd1;
    localparam logic [6:0] F7_ADD = 7'd0;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        I_ADDI,
        I_ADD,
        I_BEQ,
        I_BNE,
        I_ILLEGAL
    } instr_t;

    // Opcode/funct classification only; register-index legality depends on NREGS.
    function automatic instr_t classify(logic [31:0] ir);
        if (ir[6:0] == OP_IMM && ir[14:12] == F3_ADD) begin
            return I_ADDI;
        end
        if (ir[6:0] == OP_REG && ir[14:12] == F3_ADD && ir[31:25] == F7_ADD) begin
            return I_ADD;
        end
        if (ir[6:0] == OP_BRANCH && ir[14:12] == F3_BEQ) begin
            return I_BEQ;
        end
        if (ir[6:0] == OP_BRANCH && ir[14:12] == F3_BNE) begin
            return I_BNE;
        end
        return I_ILLEGAL;
    endfunction

endpackage

// File: rtl/rv_multicycle_core_if.sv
// Instruction-fetch handshake between the core (master) and instruction memory (slave).
// imem_req is held until a cycle with imem_valid; imem_addr is stable while waiting.
interface rv_multicycle_core_if #(
    parameter int WIDTH = 32
);

    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_valid;
    logic [31:0]      imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );

endinterface

// File: rtl/rv_regfile.sv
// Architectural register file: two combinational read ports, one write port, x0 hardwired to zero.
// x10 is exported directly so the top can expose a0 without a third read port.
module rv_regfile #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] rs1_i,
    input  logic [$clog2(NREGS)-1:0] rs2_i,
    output logic [WIDTH-1:0]         rd1_o,
    output logic [WIDTH-1:0]         rd2_o,
    input  logic                     we_i,
    input  logic [$clog2(NREGS)-1:0] wa_i,
    input  logic [WIDTH-1:0]         wd_i,
    output logic [WIDTH-1:0]         a0_o
);

    logic [WIDTH-1:0] regs_q [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (rs1_i == '0) ? '0 : regs_q[rs1_i];
    assign rd2_o = (rs2_i == '0) ? '0 : regs_q[rs2_i];
    assign a0_o  = regs_q[10];

endmodule

// File: rtl/rv_multicycle_core.sv
// Multi-cycle core executing ADDI/ADD/BEQ/BNE through FETCH/DECODE/EXECUTE/WRITEBACK.
// Stops in HALT on a taken self-loop branch (clean) or on an illegal/misaligned instruction (trap).
module rv_multicycle_core
    import rv_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               NREGS     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               CNT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    rv_multicycle_core_if.master  imem,
    output logic [WIDTH-1:0]      a0,
    output logic [CNT_WIDTH-1:0]  instret,
    output logic                  halted,
    output logic                  trap
);

    localparam int AW = $clog2(NREGS);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     pc_q, pc_d;
    logic [31:0]          ir_q, ir_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     imm_q, imm_d;
    instr_t               instr_q, instr_d;
    logic [WIDTH-1:0]     alu_q, alu_d;
    logic [WIDTH-1:0]     target_q, target_d;
    logic                 taken_q, taken_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;
    logic                 trap_q, trap_d;

    logic [WIDTH-1:0]     rd1, rd2;
    logic                 rf_we;
    instr_t               dec_instr;
    logic                 dec_legal;
    logic [WIDTH-1:0]     imm_i, imm_b, dec_imm;
    logic                 misaligned, self_loop;

    // With a reduced register file, any field index beyond NREGS makes the instruction illegal.
    function automatic logic idx_ok(logic [4:0] idx);
        return 32'(idx) < 32'(NREGS);
    endfunction

    rv_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .rs1_i (ir_q[15 +: AW]),
        .rs2_i (ir_q[20 +: AW]),
        .rd1_o (rd1),
        .rd2_o (rd2),
        .we_i  (rf_we),
        .wa_i  (ir_q[7 +: AW]),
        .wd_i  (alu_q),
        .a0_o  (a0)
    );

    always_comb begin
        dec_instr = classify(ir_q);
        imm_i     = {{(WIDTH-12){ir_q[31]}}, ir_q[31:20]};
        imm_b     = {{(WIDTH-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
        dec_imm   = (dec_instr == I_BEQ || dec_instr == I_BNE) ? imm_b : imm_i;
        unique case (dec_instr)
            I_ADDI:       dec_legal = idx_ok(ir_q[11:7]) && idx_ok(ir_q[19:15]);
            I_ADD:        dec_legal = idx_ok(ir_q[11:7]) && idx_ok(ir_q[19:15]) && idx_ok(ir_q[24:20]);
            I_BEQ, I_BNE: dec_legal = idx_ok(ir_q[19:15]) && idx_ok(ir_q[24:20]);
            default:      dec_legal = 1'b0;
        endcase
    end

    // Bit 0 of a branch target is always zero, so bit 1 alone flags a non-word-aligned target.
    assign misaligned = taken_q && target_q[1];
    assign self_loop  = taken_q && (target_q == pc_q);

    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        instr_d   = instr_q;
        alu_d     = alu_q;
        target_d  = target_q;
        taken_d   = taken_q;
        instret_d = instret_q;
        trap_d    = trap_q;
        unique case (state_q)
            FETCH: begin
                if (imem.imem_valid) begin
                    ir_d = imem.imem_rdata;
                end
            end
            DECODE: begin
                a_d     = rd1;
                b_d     = rd2;
                imm_d   = dec_imm;
                instr_d = dec_instr;
                if (!dec_legal) begin
                    trap_d = 1'b1;
                end
            end
            EXECUTE: begin
                alu_d    = a_q + ((instr_q == I_ADDI) ? imm_q : b_q);
                taken_d  = (instr_q == I_BEQ) ? (a_q == b_q) :
                           (instr_q == I_BNE) ? (a_q != b_q) : 1'b0;
                target_d = pc_q + imm_q;
            end
            WRITEBACK: begin
                if (misaligned) begin
                    trap_d = 1'b1;
                end else begin
                    pc_d      = taken_q ? target_q : pc_q + WIDTH'(4);
                    instret_d = instret_q + CNT_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            instr_q   <= I_ILLEGAL;
            alu_q     <= '0;
            target_q  <= '0;
            taken_q   <= 1'b0;
            instret_q <= '0;
            trap_q    <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            instr_q   <= instr_d;
            alu_q     <= alu_d;
            target_q  <= target_d;
            taken_q   <= taken_d;
            instret_q <= instret_d;
            trap_q    <= trap_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:     if (imem.imem_valid) state_d = DECODE;
            DECODE:    state_d = dec_legal ? EXECUTE : HALT;
            EXECUTE:   state_d = WRITEBACK;
            WRITEBACK: state_d = (misaligned || self_loop) ? HALT : FETCH;
            default:   state_d = HALT;
        endcase
    end

    // Gating with rst drops the request in the same cycle reset arrives, not at the next edge.
    always_comb begin
        imem.imem_req = (state_q == FETCH) && !rst;
        halted        = (state_q == HALT);
        rf_we         = (state_q == WRITEBACK) && (instr_q == I_ADDI || instr_q == I_ADD);
    end

    assign imem.imem_addr = pc_q;
    assign instret        = instret_q;
    assign trap           = trap_q;

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Bench for rv_multicycle_core: directed programs plus random straight-line programs,
// each compared against an instruction-level reference model with a wait-state imem responder.
module tb_rv_multicycle_core;

    localparam int          WIDTH     = 32;
    localparam int          NREGS     = 32;
    localparam int          CNT_WIDTH = 32;
    localparam logic [31:0] RPC       = 32'h0000_0100;
    localparam logic [31:0] HALT_W    = 32'h0000_0063;
    localparam int          BUDGET    = 3000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [WIDTH-1:0]     a0;
    logic [CNT_WIDTH-1:0] instret;
    logic                 halted;
    logic                 trap;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [64];
    int          wait_cfg = 0;
    int          wcnt = 0;
    logic [31:0] held_addr;
    int          addr_moves = 0;

    rv_multicycle_core_if #(.WIDTH(WIDTH)) imem ();

    rv_multicycle_core #(
        .WIDTH     (WIDTH),
        .NREGS     (NREGS),
        .RESET_PC  (RPC),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .imem    (imem),
        .a0      (a0),
        .instret (instret),
        .halted  (halted),
        .trap    (trap)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fetch_word(logic [31:0] addr);
        logic [31:0] idx;
        idx = (addr - RPC) >> 2;
        if (addr < RPC || idx >= 64 || addr[1:0] != 2'b00) return HALT_W;
        return prog[idx];
    endfunction

    // Memory responder: answers wait_cfg cycles after the request first appears.
    always @(negedge clk) begin
        if (imem.imem_req !== 1'b1) begin
            imem.imem_valid = 1'b0;
            imem.imem_rdata = 32'h0;
            wcnt = 0;
        end else begin
            if (wcnt == 0) held_addr = imem.imem_addr;
            else if (imem.imem_addr !== held_addr) addr_moves++;
            if (wcnt >= wait_cfg) begin
                imem.imem_valid = 1'b1;
                imem.imem_rdata = fetch_word(imem.imem_addr);
            end else begin
                imem.imem_valid = 1'b0;
            end
            wcnt++;
        end
    end

    function automatic logic [31:0] e_addi(int rd, int rs1, int imm);
        return {imm[11:0], 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] e_add(int rd, int rs1, int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] e_br(int f3, int rs1, int rs2, int off);
        return {off[12], off[10:5], 5'(rs2), 5'(rs1), 3'(f3), off[4:1], off[11], 7'b1100011};
    endfunction

    function automatic int pick_reg();
        case ($urandom_range(0, 4))
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 3;
            default: return 10;
        endcase
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = HALT_W;
    endtask

    // Instruction-level reference: architectural effect and cycle cost of each instruction.
    task automatic model_run(input int w, output logic [31:0] m_a0, output logic [31:0] m_ret,
                             output logic [31:0] m_pc, output logic m_halt, output logic m_trap,
                             output int m_cyc);
        logic [31:0] r [32];
        logic [31:0] pc, ir, imm, tgt;
        logic        tk;
        int          steps;
        for (int i = 0; i < 32; i++) r[i] = 32'h0;
        pc = RPC; m_ret = 0; m_cyc = 0; m_halt = 0; m_trap = 0; steps = 0;
        while (!m_halt && steps < 1000) begin
            ir = fetch_word(pc);
            if (ir[6:0] == 7'h13 && ir[14:12] == 3'd0) begin
                imm = {{20{ir[31]}}, ir[31:20]};
                if (ir[11:7] != 0) r[ir[11:7]] = r[ir[19:15]] + imm;
                pc = pc + 4; m_ret++; m_cyc += w + 4;
            end else if (ir[6:0] == 7'h33 && ir[14:12] == 3'd0 && ir[31:25] == 7'd0) begin
                if (ir[11:7] != 0) r[ir[11:7]] = r[ir[19:15]] + r[ir[24:20]];
                pc = pc + 4; m_ret++; m_cyc += w + 4;
            end else if (ir[6:0] == 7'h63 && (ir[14:12] == 3'd0 || ir[14:12] == 3'd1)) begin
                imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
                tk = (ir[14:12] == 3'd0) ? (r[ir[19:15]] == r[ir[24:20]]) : (r[ir[19:15]] != r[ir[24:20]]);
                m_cyc += w + 4;
                tgt = pc + imm;
                if (!tk) begin
                    pc = pc + 4; m_ret++;
                end else if (tgt[1]) begin
                    m_halt = 1; m_trap = 1;
                end else if (tgt == pc) begin
                    m_halt = 1; m_ret++;
                end else begin
                    pc = tgt; m_ret++;
                end
            end else begin
                m_cyc += w + 2; m_halt = 1; m_trap = 1;
            end
            steps++;
        end
        m_a0 = r[10];
        m_pc = pc;
    endtask

    task automatic do_reset(input int w);
        wait_cfg = w;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic run_to_halt(output int cycles);
        cycles = 0;
        while (halted !== 1'b1 && cycles < BUDGET) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", imem.imem_req); end
        checks++; if (a0 !== 32'h0) begin errors++; $display("FAIL reset_a0 got %h want 0", a0); end
        checks++; if (instret !== 32'h0) begin errors++; $display("FAIL reset_instret got %0d want 0", instret); end
        checks++; if ({halted, trap} !== 2'b00) begin errors++; $display("FAIL reset_status got %b want 00", {halted, trap}); end
        checks++; if (imem.imem_addr !== RPC) begin errors++; $display("FAIL reset_pc got %h want %h", imem.imem_addr, RPC); end
        clear_prog();
        do_reset(0);
        #1;
        checks++; if (imem.imem_req !== 1'b1) begin errors++; $display("FAIL release_req got %0b want 1", imem.imem_req); end
    endtask

    task automatic test_addi_pair();
        int cyc;
        clear_prog();
        prog[0] = e_addi(10, 0, 5);
        prog[1] = e_addi(10, 10, -7);
        do_reset(0);
        repeat (7) begin @(posedge clk); #1; end
        checks++; if (a0 !== 32'd5) begin errors++; $display("FAIL pair_a0_mid got %h want 5", a0); end
        @(posedge clk); #1;
        checks++; if (a0 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL pair_a0 got %h want fffffffe", a0); end
        checks++; if (instret !== 32'd2) begin errors++; $display("FAIL pair_instret got %0d want 2", instret); end
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL pair_trap got %0b want 0", trap); end
        run_to_halt(cyc);
        checks++; if (instret !== 32'd3 || halted !== 1'b1) begin errors++; $display("FAIL pair_halt got ret=%0d halted=%0b want 3/1", instret, halted); end
    endtask

    task automatic load_loop();
        clear_prog();
        prog[0] = e_addi(1, 0, 3);
        prog[1] = e_addi(10, 0, 0);
        prog[2] = e_add(10, 10, 1);
        prog[3] = e_addi(1, 1, -1);
        prog[4] = e_br(1, 1, 0, -8);
        prog[5] = e_br(0, 0, 0, 0);
    endtask

    task automatic test_loop(input int w);
        int cyc, moves0;
        load_loop();
        moves0 = addr_moves;
        do_reset(w);
        run_to_halt(cyc);
        checks++; if (halted !== 1'b1 || trap !== 1'b0) begin errors++; $display("FAIL loop_w%0d_status got h=%0b t=%0b want 1/0", w, halted, trap); end
        checks++; if (a0 !== 32'd6) begin errors++; $display("FAIL loop_w%0d_a0 got %0d want 6", w, a0); end
        checks++; if (instret !== 32'd12) begin errors++; $display("FAIL loop_w%0d_instret got %0d want 12", w, instret); end
        checks++; if (cyc !== 12 * (4 + w)) begin errors++; $display("FAIL loop_w%0d_cycles got %0d want %0d", w, cyc, 12 * (4 + w)); end
        checks++; if (addr_moves !== moves0) begin errors++; $display("FAIL loop_w%0d_addr_stable got %0d moves want 0", w, addr_moves - moves0); end
        checks++; if (imem.imem_addr !== RPC + 32'h14) begin errors++; $display("FAIL loop_w%0d_pc got %h want %h", w, imem.imem_addr, RPC + 32'h14); end
    endtask

    task automatic test_x0_illegal();
        int cyc;
        clear_prog();
        prog[0] = e_addi(10, 0, 7);
        prog[1] = e_addi(0, 0, 9);
        prog[2] = e_add(10, 0, 0);
        do_reset(0);
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (a0 !== 32'd7) begin errors++; $display("FAIL x0_a0_pre got %0d want 7", a0); end
        run_to_halt(cyc);
        checks++; if (a0 !== 32'd0) begin errors++; $display("FAIL x0_a0 got %0d want 0", a0); end
        checks++; if (instret !== 32'd4) begin errors++; $display("FAIL x0_instret got %0d want 4", instret); end
        clear_prog();
        prog[0] = e_addi(10, 0, 3);
        prog[1] = 32'hFFFF_FFFF;
        do_reset(0);
        run_to_halt(cyc);
        checks++; if (halted !== 1'b1 || trap !== 1'b1) begin errors++; $display("FAIL illegal_status got h=%0b t=%0b want 1/1", halted, trap); end
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL illegal_req got %0b want 0", imem.imem_req); end
        checks++; if (instret !== 32'd1) begin errors++; $display("FAIL illegal_instret got %0d want 1", instret); end
        checks++; if (cyc !== 6) begin errors++; $display("FAIL illegal_cycles got %0d want 6", cyc); end
        checks++; if (imem.imem_addr !== RPC + 32'h4 || a0 !== 32'd3) begin errors++; $display("FAIL illegal_state got pc=%h a0=%0d want %h/3", imem.imem_addr, a0, RPC + 32'h4); end
    endtask

    task automatic test_misaligned_overflow();
        int cyc;
        clear_prog();
        prog[0] = e_br(0, 0, 0, 6);
        do_reset(0);
        run_to_halt(cyc);
        checks++; if (halted !== 1'b1 || trap !== 1'b1) begin errors++; $display("FAIL misalign_status got h=%0b t=%0b want 1/1", halted, trap); end
        checks++; if (imem.imem_addr !== RPC) begin errors++; $display("FAIL misalign_pc got %h want %h", imem.imem_addr, RPC); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL misalign_instret got %0d want 0", instret); end
        clear_prog();
        prog[0] = e_addi(10, 0, -1);
        prog[1] = e_addi(10, 10, 1);
        do_reset(0);
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (a0 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ovf_a0_pre got %h want ffffffff", a0); end
        run_to_halt(cyc);
        checks++; if (a0 !== 32'h0 || trap !== 1'b0) begin errors++; $display("FAIL ovf_a0 got %h t=%0b want 0/0", a0, trap); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        clear_prog();
        prog[0] = e_addi(10, 0, 5);
        prog[1] = e_addi(10, 10, -7);
        do_reset(3);
        repeat (9) begin @(posedge clk); #1; end
        checks++; if (imem.imem_req !== 1'b1 || a0 !== 32'd5) begin errors++; $display("FAIL midfetch_pre got req=%0b a0=%0d want 1/5", imem.imem_req, a0); end
        rst = 1'b1;
        #1;
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL midfetch_req got %0b want 0", imem.imem_req); end
        checks++; if (a0 !== 32'h0 || instret !== 32'h0) begin errors++; $display("FAIL midfetch_state got a0=%0d ret=%0d want 0/0", a0, instret); end
        checks++; if (imem.imem_addr !== RPC) begin errors++; $display("FAIL midfetch_pc got %h want %h", imem.imem_addr, RPC); end
        do_reset(0);
        repeat (6) begin @(posedge clk); #1; end
        checks++; if (a0 !== 32'd5 || instret !== 32'd1) begin errors++; $display("FAIL midexec_pre got a0=%0d ret=%0d want 5/1", a0, instret); end
        rst = 1'b1;
        #1;
        checks++; if (imem.imem_req !== 1'b0 || a0 !== 32'h0 || instret !== 32'h0) begin
            errors++; $display("FAIL midexec_state got req=%0b a0=%0d ret=%0d want 0/0/0", imem.imem_req, a0, instret);
        end
        do_reset(0);
        run_to_halt(cyc);
        checks++; if (a0 !== 32'hFFFF_FFFE || instret !== 32'd3 || cyc !== 12) begin
            errors++; $display("FAIL restart got a0=%h ret=%0d cyc=%0d want fffffffe/3/12", a0, instret, cyc);
        end
    endtask

    task automatic test_random();
        logic [31:0] m_a0, m_ret, m_pc;
        logic        m_halt, m_trap;
        int          m_cyc, cyc, n, w, k, off;
        for (int t = 0; t < 8; t++) begin
            clear_prog();
            n = int'($urandom_range(6, 14));
            for (int i = 0; i < n; i++) begin
                k = int'($urandom_range(0, 9));
                if (k < 5) begin
                    prog[i] = e_addi(pick_reg(), pick_reg(), int'($urandom_range(0, 4095)) - 2048);
                end else if (k < 8) begin
                    prog[i] = e_add(pick_reg(), pick_reg(), pick_reg());
                end else begin
                    off = ($urandom_range(0, 3) == 0) ? 6 : 8;
                    prog[i] = e_br(int'($urandom_range(0, 1)), pick_reg(), pick_reg(), off);
                end
            end
            w = int'($urandom_range(0, 2));
            model_run(w, m_a0, m_ret, m_pc, m_halt, m_trap, m_cyc);
            do_reset(w);
            run_to_halt(cyc);
            checks++; if (a0 !== m_a0) begin errors++; $display("FAIL rnd%0d_a0 got %h want %h", t, a0, m_a0); end
            checks++; if (instret !== m_ret) begin errors++; $display("FAIL rnd%0d_instret got %0d want %0d", t, instret, m_ret); end
            checks++; if ({halted, trap} !== {m_halt, m_trap}) begin errors++; $display("FAIL rnd%0d_status got %b want %b", t, {halted, trap}, {m_halt, m_trap}); end
            checks++; if (imem.imem_addr !== m_pc) begin errors++; $display("FAIL rnd%0d_pc got %h want %h", t, imem.imem_addr, m_pc); end
            checks++; if (cyc !== m_cyc) begin errors++; $display("FAIL rnd%0d_cycles got %0d want %0d", t, cyc, m_cyc); end
        end
    endtask

    initial begin
        test_reset();
        test_addi_pair();
        test_loop(0);
        test_loop(3);
        test_x0_illegal();
        test_misaligned_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
